// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial pattern detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_detect_pkg;

    // Hunt progress: no history, partial history, full PAT_W-bit window
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    // Fill counter must represent 0..pat_w inclusive
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Latency: q updates one cycle after inc/clr.
// Backpressure: none; holds at all-ones until cleared.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    // Count events, stick at the maximum, clear wins over a same-cycle event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {CNT_W{1'b1}})) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial sync-word hunter: matches a 1-bit stream against a loadable PAT_W-bit pattern.
// Latency: y pulses one cycle after the beat that completes a match.
// Backpressure: none; in_valid=0 freezes the hunt. Optional match counter via SEQ_DET_MATCH_CNT_EN.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PAT_RST = 3'b110,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             x,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    output logic             y,
    output logic             armed
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt,
    input  logic             cnt_clr
`endif
);

    localparam int FILL_W = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    // Reject unusable configurations at elaboration time
    if (PAT_W < 2 || PAT_W > 32 || CNT_W < 1) begin : g_bad_param
        $error("seq_detect_param: PAT_W must be 2..32 and CNT_W >= 1");
    end

    logic [PAT_W-1:0]  pattern;
    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              beat;
    logic              hit;
    state_t            state;
    state_t            state_nxt;

    // A config load consumes the cycle, so the bit arriving with it is dropped
    assign beat       = in_valid && !cfg_load;
    assign hist_shift = {hist[PAT_W-2:0], x};
    assign fill_inc   = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    assign hit        = beat && (fill_inc == FILL_FULL) && (hist_shift == pattern);

    // Pattern register, history shifter and fill counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern <= PAT_RST;
            hist    <= '0;
            fill    <= '0;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            hist    <= '0;
            fill    <= '0;
        end else if (beat) begin
            if (hit && !OVERLAP) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= hist_shift;
                fill <= fill_inc;
            end
        end
    end

    // Next state follows the fill level; restarts on load or non-overlapping match
    always_comb begin
        state_nxt = state;
        if (cfg_load) begin
            state_nxt = EMPTY;
        end else if (beat) begin
            if (hit && !OVERLAP) begin
                state_nxt = EMPTY;
            end else if (fill_inc == FILL_FULL) begin
                state_nxt = ARMED;
            end else begin
                state_nxt = FILLING;
            end
        end
    end

    // State, registered armed flag and registered match pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            armed <= 1'b0;
            y     <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= (state_nxt == ARMED);
            y     <= hit;
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit),
        .clr   (cnt_clr),
        .q     (match_cnt)
    );
`endif

endmodule
